// File: rtl/lap_memory_pkg.sv
// Shared stopwatch constants for the lap memory block.
// Holds the digit and snapshot widths, the default lap depth, the counter
// width, the LIVE/RECALL_ST state encoding, and the packed time-snapshot
// layout {minutes, sec_msb, sec_lsb, tenths, hundredths}.
package lap_memory_pkg;

   localparam int DIGIT_W   = 4;
   localparam int SNAP_W    = 20;
   localparam int DEPTH_DEF = 8;
   localparam int CNT_W     = 4;   // holds 0..15, enough for the largest DEPTH

   typedef enum logic {
      LIVE      = 1'b0,
      RECALL_ST = 1'b1
   } state_e;

   // Minutes sit in the most significant nibble, so the struct bit pattern
   // is exactly the stored 20-bit snapshot.
   typedef struct packed {
      logic [DIGIT_W-1:0] minutes;
      logic [DIGIT_W-1:0] sec_msb;
      logic [DIGIT_W-1:0] sec_lsb;
      logic [DIGIT_W-1:0] tenths;
      logic [DIGIT_W-1:0] hundredths;
   } digits_t;

endpackage

// File: rtl/lap_memory_if.sv
// Bus between the stopwatch control/counters and the lap memory.
//   clr       : synchronous clear from the stopwatch FSM
//   lap       : debounced lap button (level)
//   recall    : debounced recall button (level)
//   time_in   : live BCD time digits
//   time_out  : digits forwarded to the display decoders
//   lap_count : number of stored laps
//   view      : high while a stored lap is displayed
//   full      : high when every slot is used
// master = stopwatch side, slave = lap memory.
interface lap_memory_if;
   import lap_memory_pkg::*;

   logic             clr;
   logic             lap;
   logic             recall;
   digits_t          time_in;
   digits_t          time_out;
   logic [CNT_W-1:0] lap_count;
   logic             view;
   logic             full;

   modport master (
      output clr, lap, recall, time_in,
      input  time_out, lap_count, view, full
   );

   modport slave (
      input  clr, lap, recall, time_in,
      output time_out, lap_count, view, full
   );

endinterface

// File: rtl/lap_memory_edge_det.sv
// lap_edge_det: synchronous rising-edge detector.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset, clears the history bit
//   level_i : level input
//   rise_o  : high for the one cycle where level_i is 1 and was 0 last edge
// The history bit is cleared by reset, so a level already high at reset
// release yields one edge on the first cycle after release.
module lap_edge_det (
   input  logic clk_i,
   input  logic rst_i,
   input  logic level_i,
   output logic rise_o
);

   logic prev_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) prev_q <= 1'b0;
      else       prev_q <= level_i;
   end

   assign rise_o = level_i & ~prev_q;

endmodule

// File: rtl/lap_memory.sv
// lap_memory: stores up to DEPTH lap snapshots of the stopwatch time and
// lets the user step through them on the display.
//   clk_i : 100 Hz timebase clock
//   rst_i : synchronous active-high reset (priority over everything)
//   bus   : lap_memory_if slave (clr/lap/recall/time in, digits/status out)
// All outputs are registered. In LIVE the display shows the previous-cycle
// live digits; in RECALL_ST it shows the stored slot at the read index.
module lap_memory
   import lap_memory_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic         clk_i,
   input  logic         rst_i,
   lap_memory_if.slave  bus
);

   localparam int IDX_W = $clog2(DEPTH);

   logic              lap_rise, rec_rise;
   logic              lap_ok, rec_ok, wr_en;
   logic [SNAP_W-1:0] mem_q [DEPTH];
   logic [CNT_W-1:0]  count_q, count_d;
   logic [IDX_W-1:0]  idx_q, idx_inc;
   state_e            state_q;
   digits_t           out_q;
   logic              full_q;

   lap_edge_det u_lap_det (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .level_i (bus.lap),
      .rise_o  (lap_rise)
   );

   lap_edge_det u_rec_det (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .level_i (bus.recall),
      .rise_o  (rec_rise)
   );

   // Edges arriving together with a clear are dropped; the detectors' history
   // still advances so a held button does not re-fire after the clear.
   assign lap_ok  = lap_rise & ~bus.clr;
   assign rec_ok  = rec_rise & ~bus.clr;
   assign wr_en   = lap_ok && (count_q < CNT_W'(DEPTH));
   assign idx_inc = idx_q + IDX_W'(1);

   always_comb begin
      count_d = count_q;
      if (bus.clr)    count_d = '0;
      else if (wr_en) count_d = count_q + CNT_W'(1);
   end

   // Plain array, no reset: slots at or above lap_count are never shown.
   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[count_q[IDX_W-1:0]] <= bus.time_in;
   end

   // Recall decisions use count_q, i.e. the count before a same-cycle capture.
   // The read index is always below that count, so it never addresses the
   // slot being written in the same cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= LIVE;
         idx_q   <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         out_q   <= '0;
      end else begin
         count_q <= count_d;
         full_q  <= (count_d == CNT_W'(DEPTH));
         if (bus.clr) begin
            state_q <= LIVE;
            idx_q   <= '0;
            out_q   <= bus.time_in;
         end else begin
            case (state_q)
               LIVE: begin
                  if (rec_ok && count_q != '0) begin
                     state_q <= RECALL_ST;
                     idx_q   <= '0;
                     out_q   <= digits_t'(mem_q[0]);
                  end else begin
                     out_q   <= bus.time_in;
                  end
               end
               RECALL_ST: begin
                  if (rec_ok) begin
                     if (CNT_W'(idx_q) + CNT_W'(1) < count_q) begin
                        idx_q <= idx_inc;
                        out_q <= digits_t'(mem_q[idx_inc]);
                     end else begin
                        state_q <= LIVE;
                        idx_q   <= '0;
                        out_q   <= bus.time_in;
                     end
                  end else begin
                     out_q <= digits_t'(mem_q[idx_q]);
                  end
               end
            endcase
         end
      end
   end

   assign bus.time_out  = out_q;
   assign bus.lap_count = count_q;
   assign bus.view      = (state_q == RECALL_ST);
   assign bus.full      = full_q;

endmodule

// File: tb/tb_lap_memory.sv
// Self-checking bench for lap_memory. A behavioural model predicts the
// registered outputs for each clock edge; predictions go into a scoreboard
// queue and are popped and compared once the DUT has updated. Directed
// scenarios also check literal expected values.
module tb_lap_memory;
   import lap_memory_pkg::*;

   localparam int DEPTH = 8;

   typedef struct packed {
      logic [19:0] dig;
      logic [3:0]  cnt;
      logic        view;
      logic        full;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;
   exp_t sb_q[$];

   // reference model state
   logic        m_lprev, m_rprev, m_view;
   logic [3:0]  m_cnt;
   int          m_idx;
   logic [19:0] m_mem [16];
   logic [19:0] m_out;

   lap_memory_if bus();

   lap_memory #(.DEPTH(DEPTH)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic model_step();
      logic       le, re;
      logic [3:0] old;
      if (rst) begin
         m_lprev = 0; m_rprev = 0; m_cnt = 0; m_view = 0; m_idx = 0; m_out = '0;
      end else begin
         le = bus.lap & ~m_lprev;
         re = bus.recall & ~m_rprev;
         m_lprev = bus.lap;
         m_rprev = bus.recall;
         if (bus.clr) begin
            m_cnt = 0; m_view = 0; m_idx = 0;
         end else begin
            old = m_cnt;
            if (le && m_cnt < DEPTH) begin
               m_mem[m_cnt] = bus.time_in;
               m_cnt++;
            end
            if (!m_view) begin
               if (re && old > 0) begin m_view = 1; m_idx = 0; end
            end else if (re) begin
               if (m_idx < int'(old) - 1) m_idx++;
               else begin m_view = 0; m_idx = 0; end
            end
         end
         m_out = m_view ? m_mem[m_idx] : bus.time_in;
      end
   endtask

   // one clock: predict, push, then pop and compare after the edge
   task automatic cyc();
      exp_t e;
      @(posedge clk);
      model_step();
      sb_q.push_back('{dig: m_out, cnt: m_cnt, view: m_view, full: (m_cnt == DEPTH)});
      #1;
      e = sb_q.pop_front();
      chk("digits", 32'(bus.time_out), 32'(e.dig));
      chk("lap_count", 32'(bus.lap_count), 32'(e.cnt));
      chk("view", 32'(bus.view), 32'(e.view));
      chk("full", 32'(bus.full), 32'(e.full));
   endtask

   task automatic set_t(input logic [19:0] v);
      bus.time_in = v;
   endtask

   task automatic pulse_rec();
      bus.recall = 1; cyc();
      bus.recall = 0; cyc();
   endtask

   initial begin
      rst = 1; bus.clr = 0; bus.lap = 0; bus.recall = 0; set_t(20'h0);
      cyc(); cyc();
      chk("rst_digits", 32'(bus.time_out), 32'h0);
      chk("rst_count", 32'(bus.lap_count), 32'h0);
      rst = 0;

      // live pass-through
      set_t(20'h35291); cyc();
      chk("live_digits", 32'(bus.time_out), 32'h35291);
      chk("live_view", 32'(bus.view), 32'h0);

      // capture two laps, then step through them and back to live
      set_t(20'h01234); bus.lap = 1; cyc(); bus.lap = 0; cyc();
      set_t(20'h02567); bus.lap = 1; cyc(); bus.lap = 0; cyc();
      chk("two_laps", 32'(bus.lap_count), 32'd2);
      set_t(20'h09999);
      bus.recall = 1; cyc();
      chk("recall0_dig", 32'(bus.time_out), 32'h01234);
      chk("recall0_view", 32'(bus.view), 32'h1);
      bus.recall = 0; cyc();
      bus.recall = 1; cyc();
      chk("recall1_dig", 32'(bus.time_out), 32'h02567);
      chk("recall1_view", 32'(bus.view), 32'h1);
      bus.recall = 0; cyc();
      bus.recall = 1; cyc();
      chk("wrap_dig", 32'(bus.time_out), 32'h09999);
      chk("wrap_view", 32'(bus.view), 32'h0);
      bus.recall = 0; cyc();

      // empty recall
      bus.clr = 1; cyc(); bus.clr = 0;
      bus.recall = 1; cyc();
      chk("empty_view", 32'(bus.view), 32'h0);
      bus.recall = 0; cyc();

      // fill: nine laps, ninth discarded
      for (int i = 0; i < 9; i++) begin
         set_t(20'h10000 + 20'(i));
         bus.lap = 1; cyc(); bus.lap = 0; cyc();
      end
      chk("full_count", 32'(bus.lap_count), 32'd8);
      chk("full_flag", 32'(bus.full), 32'h1);
      for (int i = 0; i < 8; i++) begin
         bus.recall = 1; cyc();
         if (i == 7) chk("slot7", 32'(bus.time_out), 32'h10007);
         bus.recall = 0; cyc();
      end
      pulse_rec();

      // simultaneous lap and recall edges with one stored lap
      bus.clr = 1; cyc(); bus.clr = 0;
      set_t(20'h00111); bus.lap = 1; cyc(); bus.lap = 0; cyc();
      set_t(20'h00222); bus.lap = 1; bus.recall = 1; cyc();
      chk("simul_view", 32'(bus.view), 32'h1);
      chk("simul_count", 32'(bus.lap_count), 32'd2);
      chk("simul_dig", 32'(bus.time_out), 32'h00111);
      bus.lap = 0; bus.recall = 0; cyc();

      // clear while recalling
      set_t(20'h04444); bus.clr = 1; cyc();
      chk("clr_view", 32'(bus.view), 32'h0);
      chk("clr_count", 32'(bus.lap_count), 32'h0);
      chk("clr_dig", 32'(bus.time_out), 32'h04444);
      bus.clr = 0; cyc();

      // reset with lap held: one capture after release
      bus.lap = 1; rst = 1; cyc(); cyc();
      chk("rst2_dig", 32'(bus.time_out), 32'h0);
      chk("rst2_count", 32'(bus.lap_count), 32'h0);
      rst = 0; cyc();
      chk("post_rst_count", 32'(bus.lap_count), 32'd1);
      cyc(); cyc();
      chk("held_count", 32'(bus.lap_count), 32'd1);
      bus.lap = 0; cyc();

      // random traffic, non-BCD digits included
      for (int i = 0; i < 400; i++) begin
         bus.lap    = ($urandom_range(0, 2) == 0);
         bus.recall = ($urandom_range(0, 2) == 0);
         bus.clr    = ($urandom_range(0, 40) == 0);
         rst        = ($urandom_range(0, 150) == 0);
         set_t(20'($urandom));
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lap_memory.md
LAP_MEMORY -- requirements
Module: lap_memory

Interface
REQ-001 Parameter DEPTH, default 8, number of lap snapshots stored (2..15).
REQ-002 CLK  in  1  system clock; the 100 Hz timebase domain that also drives the time counters.
REQ-003 RESET  in  1  synchronous, active-high reset.
REQ-004 CLR  in  1  synchronous clear from the stopwatch state machine; empties memory and forces live mode.
REQ-005 LAP  in  1  debounced lap button, level.
REQ-006 RECALL  in  1  debounced recall button, level.
REQ-007 HUNDREDTHS_IN, TENTHS_IN, SEC_LSB_IN, SEC_MSB_IN, MINUTES_IN  in  4 each  live BCD time digits.
REQ-008 HUNDREDTHS_OUT, TENTHS_OUT, SEC_LSB_OUT, SEC_MSB_OUT, MINUTES_OUT  out  4 each  digits forwarded to hex2led.
REQ-009 LAP_COUNT  out  4  number of stored laps, 0..DEPTH.
REQ-010 VIEW  out  1  high while a stored lap is displayed.
REQ-011 FULL  out  1  high when LAP_COUNT == DEPTH.

Function
REQ-012 Rising-edge detection on LAP and RECALL: an edge occurs at clock edge k when the input is 1 at k and was 0 at k-1; a held level gives exactly one edge.
REQ-013 Snapshot = {MINUTES_IN, SEC_MSB_IN, SEC_LSB_IN, TENTHS_IN, HUNDREDTHS_IN}, 20 bits, sampled at the same clock edge as the LAP edge.
REQ-014 LAP edge with LAP_COUNT < DEPTH: write the snapshot to slot LAP_COUNT; LAP_COUNT increments by 1, visible the following cycle.
REQ-015 LAP edge with FULL=1: the snapshot is discarded; memory and LAP_COUNT are unchanged.
REQ-016 State machine has two states, LIVE and RECALL_ST; state LIVE means VIEW=0.
REQ-017 LIVE + RECALL edge + LAP_COUNT>0: go to RECALL_ST with read index 0.
REQ-018 LIVE + RECALL edge + LAP_COUNT==0: stay in LIVE; no other effect.
REQ-019 RECALL_ST + RECALL edge: if read index < LAP_COUNT-1, increment the index; otherwise return to LIVE (wrap to live display).
REQ-020 A simultaneous LAP edge and RECALL edge both take effect; the recall decision uses the LAP_COUNT value from before the increment.
REQ-021 Laps keep being captured while in RECALL_ST; the displayed slot does not change because of a capture.
REQ-022 Outputs are registered. In LIVE, each *_OUT equals the corresponding *_IN from the previous cycle (1-cycle latency).
REQ-023 In RECALL_ST, the *_OUT digits equal the stored slot at the read index, starting the cycle after the transition or index change.
REQ-024 Digit values are not range-checked; non-BCD inputs are stored and forwarded unchanged.
REQ-025 CLR=1: LAP_COUNT=0, state LIVE, read index 0; LAP and RECALL edges in the same cycle are ignored; edge-detect history still updates.
REQ-026 Memory contents need not be cleared by CLR or RESET; slots at or above LAP_COUNT are never displayed.

Reset
REQ-027 RESET=1 at a clock edge: all *_OUT=0, LAP_COUNT=0, VIEW=0, FULL=0, state LIVE, read index 0, edge-detect history registers = 0.
REQ-028 RESET has priority over CLR, LAP and RECALL.
REQ-029 If LAP is held high through the release of RESET, it produces one edge on the first cycle after release.

Structure
REQ-030 The shared stopwatch constants file holds DIGIT_W=4, SNAP_W=20, default DEPTH and the LIVE/RECALL_ST state encodings.
REQ-031 Sub-module lap_edge_det (synchronous rising-edge detector, RESET input) is instantiated once each for LAP and RECALL.
REQ-032 Storage is a DEPTH x SNAP_W register array written synchronously, suitable for distributed RAM.

Verification
REQ-033 Live pass-through: inputs 3,5,2,9,1 (min..hund) -> the same digits on the outputs 1 cycle later; VIEW=0.
REQ-034 Capture and recall: lap at 0:12.34, then lap at 0:25.67, then three RECALL edges -> displays 1,2,3,4 / 2,5,6,7 / then live; VIEW 1,1,0.
REQ-035 Full: 9 LAP edges with DEPTH=8 -> LAP_COUNT=8, FULL=1, and slot 7 holds the 8th snapshot, not the 9th.
REQ-036 Empty recall: RECALL edge with LAP_COUNT=0 -> VIEW remains 0.
REQ-037 Simultaneous edges: LAP_COUNT=1 in LIVE, LAP and RECALL edges in the same cycle -> RECALL_ST with index 0 and LAP_COUNT=2.
REQ-038 Clear/reset mid-recall: CLR asserted in RECALL_ST -> next cycle VIEW=0, LAP_COUNT=0, live digits shown; RESET with LAP held high -> all outputs 0, then exactly one capture after release.
